window_3x3_gen: RTL and testbench
=================================

// Module: window_3x3_gen
// PURPOSE
//  Streaming 3x3 neighbourhood generator that sits directly upstream of the conv stage.
//  Accepts a raster-order frame, one RGB444 pixel per beat, and buffers two image lines.
//  For every interior pixel it emits one 3x3 window for the convolution kernel.
//  Pipeline back-pressure is carried end to end by valid/ready handshakes.
// PARAMETERS
//  PIX_W   12  pixel width in bits, {R[11:8],G[7:4],B[3:0]}
//  IMG_W   64  pixels per line, >=3
//  IMG_H   64  lines per frame, >=3
// PORTS
//  clk         in   1          single clock, rising edge
//  rst         in   1          asynchronous, active-low reset
//  ld          in   1          start-of-frame pulse; ignored unless in IDLE
//  in_valid    in   1          in_pixel is valid
//  in_ready    out  1          block accepts in_pixel this cycle
//  in_pixel    in   PIX_W      raster-order input pixel
//  out_valid   out  1          win holds a valid window
//  out_ready   in   1          conv consumes the window this cycle
//  win         out  9*PIX_W    window; tap (i,j) at [PIX_W*(3*i+j) +: PIX_W]; i=row (0=top), j=col (0=left)
//  win_row     out  $clog2(IMG_H)  centre row of the window
//  win_col     out  $clog2(IMG_W)  centre column of the window
//  complete    out  1          one-cycle pulse after the last window of a frame is consumed
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; row/col counters=0; 3x3 taps=0; line-buffer contents don't-care.
//   Outputs under reset: in_ready=0, out_valid=0, win=0, win_row=0, win_col=0, complete=0.
//  Line buffers: two IMG_W-deep RAMs/shift registers, LB1 = line r-1 and LB2 = line r-2.
//   When pixel p(r,c) is accepted:
//    - taps shift one column left;
//    - new right column = {LB2[c], LB1[c], p} (top to bottom);
//    - LB2[c] <= LB1[c] and LB1[c] <= p.
//  Input acceptance: accept = in_valid && in_ready.
//   in_ready = (state==RUN) && !pix_done && (!out_valid || out_ready).
//  Counters: col increments on each accept and wraps IMG_W-1 -> 0; row increments on that wrap.
//   pix_done sets once p(IMG_H-1, IMG_W-1) is accepted.
//  Window emission:
//   - accepting p(r,c) with r>=2 && c>=2 registers a window centred at (r-1,c-1);
//   - latency is 1 cycle: out_valid rises on the cycle after the accept;
//   - win, win_row and win_col are registered together with out_valid;
//   - windows per frame = (IMG_H-2)*(IMG_W-2); no window straddles a line wrap;
//   - out_valid stays high and win/win_row/win_col stay stable until out_ready=1;
//   - out_valid drops after the handshake unless a new window is loaded in the same cycle.
//  FSM:
//   - IDLE -> RUN on ld=1; counters, pix_done and taps clear on entry.
//   - RUN -> DONE when pix_done=1 and no window is pending (out_valid=0, or out_valid=1 with out_ready=1).
//   - DONE asserts complete for exactly 1 cycle, then goes to IDLE.
//   - ld is ignored in RUN and DONE. A new frame requires a fresh ld.
//  Simultaneous handshake: a window handshake and a pixel accept in the same cycle is legal.
//   The next window replaces the current one with no bubble.
//  Input gaps: in_valid=0 holds all state; no window is generated.
//  Mid-frame reset: immediate return to IDLE with all outputs at reset values; the partial frame is discarded.
//  Pixel arithmetic: none; pixels are passed through bit-exact.
// TESTING
//  1. IMG_W=5, IMG_H=5, in_pixel=r*5+c, in_valid=1, out_ready=1:
//     - expect 9 windows in order;
//     - first window: win_row=1, win_col=1, taps 0,1,2,5,6,7,10,11,12;
//     - last window: taps 12,13,14,17,18,19,22,23,24;
//     - then complete is a single pulse.
//  2. Same frame with out_ready toggling 1 cycle on, 2 off:
//     - in_ready=0 while out_valid=1 && out_ready=0;
//     - win stays stable while stalled;
//     - the window sequence is identical to test 1.
//  3. Random in_valid gaps (~50%): window count and contents match test 1; no spurious out_valid.
//  4. Reset mid-frame after pixel 12:
//     - all outputs 0 asynchronously, state IDLE;
//     - after ld, a full frame reproduces test 1 exactly.
//  5. ld pulsed during RUN and DONE: no effect, no counter clear; the window stream is unchanged.
//  6. Two back-to-back frames (ld one cycle after complete), second frame = 100+r*5+c:
//     - the first window of frame 2 has taps 100,101,102,105,...;
//     - no frame-1 data leaks into frame 2.

Source files
------------

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator for a raster-order frame.
// Two line buffers hold the previous two lines; a 3x3 tap register shifts one
// column per accepted pixel, and every interior pixel yields one registered window.
//
// Handshake rule on both ports: a beat transfers on a rising clock edge where
// valid && ready are both high. A producer holding valid keeps its payload stable
// until that edge. in_ready never depends on in_valid, and out_valid never
// depends on out_ready.
module window_3x3_gen #(
    parameter int PIX_W = 12,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PIX_W-1:0]           in_pixel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [9*PIX_W-1:0]         win,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       complete,
    output logic [1:0]                 state_dbg
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [RW-1:0]       row;
    logic [CW-1:0]       col;
    logic                pix_done;
    logic [9*PIX_W-1:0]  taps;
    logic [9*PIX_W-1:0]  next_taps;
    logic [PIX_W-1:0]    lb1 [IMG_W];
    logic [PIX_W-1:0]    lb2 [IMG_W];
    logic                accept;
    logic                emit;

    assign state_dbg = state;

    // A new pixel is taken only while running, before the frame is complete,
    // and when the output register is free or being drained this same cycle.
    assign in_ready = (state == S_RUN) && !pix_done && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Interior pixels only: the window centred one row up and one column left.
    assign emit = accept && (row >= RW'(2)) && (col >= CW'(2));

    // Next tap contents: shift columns left, new right column from LB2/LB1/pixel.
    always_comb begin
        next_taps = '0;
        for (int i = 0; i < 3; i++) begin
            next_taps[PIX_W*(3*i)   +: PIX_W] = taps[PIX_W*(3*i+1) +: PIX_W];
            next_taps[PIX_W*(3*i+1) +: PIX_W] = taps[PIX_W*(3*i+2) +: PIX_W];
        end
        next_taps[PIX_W*2 +: PIX_W] = lb2[col];
        next_taps[PIX_W*5 +: PIX_W] = lb1[col];
        next_taps[PIX_W*8 +: PIX_W] = in_pixel;
    end

    // Line buffers age one line per accepted pixel; contents need no reset
    // because no window is emitted until both lines hold current-frame data.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col] <= lb1[col];
            lb1[col] <= in_pixel;
        end
    end

    // Frame FSM with counters, tap register and the registered window output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            row       <= '0;
            col       <= '0;
            pix_done  <= 1'b0;
            taps      <= '0;
            out_valid <= 1'b0;
            win       <= '0;
            win_row   <= '0;
            win_col   <= '0;
            complete  <= 1'b0;
        end else begin
            complete <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ld) begin
                        state    <= S_RUN;
                        row      <= '0;
                        col      <= '0;
                        pix_done <= 1'b0;
                        taps     <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        taps <= next_taps;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        if ((row == ROW_LAST) && (col == COL_LAST)) begin
                            pix_done <= 1'b1;
                        end
                    end
                    // A fresh window overwrites a drained one with no bubble.
                    if (emit) begin
                        out_valid <= 1'b1;
                        win       <= next_taps;
                        win_row   <= row - RW'(1);
                        win_col   <= col - CW'(1);
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (pix_done && (!out_valid || out_ready)) begin
                        state    <= S_DONE;
                        complete <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 5x5 frame.
module tb_window_3x3_gen;

    localparam int PIX_W = 12;
    localparam int IMG_W = 5;
    localparam int IMG_H = 5;
    localparam int WW    = 9 * PIX_W;
    localparam int EW    = WW + 6;

    logic              clk;
    logic              rst;
    logic              ld;
    logic              in_valid;
    logic              in_ready;
    logic [PIX_W-1:0]  in_pixel;
    logic              out_valid;
    logic              out_ready;
    logic [WW-1:0]     win;
    logic [2:0]        win_row;
    logic [2:0]        win_col;
    logic              complete;
    logic [1:0]        state_dbg;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] held;
    bit            stalled_prev;
    int            n_checks;
    int            n_fail;
    int            pix_idx;
    int            n_win;
    int            n_complete;
    int            base;

    window_3x3_gen #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .win       (win),
        .win_row   (win_row),
        .win_col   (win_col),
        .complete  (complete),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [EW-1:0] exp_win(input int b, input int r, input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[PIX_W*(3*i+j) +: PIX_W] = PIX_W'(b + (r - 1 + i) * IMG_W + (c - 1 + j));
        return {3'(r), 3'(c), w};
    endfunction

    function automatic logic [EW-1:0] obs_win();
        return {win_row, win_col, win};
    endfunction

    task automatic load_expected(input int b);
        for (int r = 1; r <= IMG_H - 2; r++)
            for (int c = 1; c <= IMG_W - 2; c++)
                exp_q.push_back(exp_win(b, r, c));
    endtask

    // One clock cycle: drive at the falling edge, check, advance to the next falling edge.
    task automatic cycle(input bit vld, input bit rdy, input bit ld_v);
        in_valid  = vld && (pix_idx < IMG_W * IMG_H);
        in_pixel  = PIX_W'(base + pix_idx);
        out_ready = rdy;
        ld        = ld_v;
        #1;
        if (out_valid && !out_ready)
            check("stall_in_ready", 128'(in_ready), 128'(0));
        if (stalled_prev)
            check("stall_hold", 128'({out_valid, obs_win()}), 128'({1'b1, held}));
        if (out_valid && out_ready) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL extra_window observed=%0d windows expected=%0d", n_win + 1, (IMG_W-2)*(IMG_H-2));
            end
            if (exp_q.size() != 0)
                check("window", 128'(obs_win()), 128'(exp_q.pop_front()));
            n_win++;
        end
        if (complete) begin
            check("complete_after_last", 128'(n_win), 128'((IMG_W-2)*(IMG_H-2)));
            n_complete++;
        end
        stalled_prev = out_valid && !out_ready;
        held         = obs_win();
        if (in_valid && in_ready) pix_idx++;
        @(negedge clk);
    endtask

    // mode 0: streaming, 1: out_ready 1-on/2-off, 2: random in_valid gaps, 3: ld in RUN and DONE
    task automatic run_frame(input int b, input int mode, input int abort_at, input int tail);
        int  k;
        int  after;
        bit  stop;
        bit  vld;
        bit  rdy;
        bit  ldp;
        base = b; pix_idx = 0; n_win = 0; n_complete = 0; stalled_prev = 1'b0;
        exp_q.delete();
        load_expected(b);
        cycle(1'b0, 1'b1, 1'b1);
        k = 0; after = 0; stop = 1'b0;
        while (k < 400 && after < tail && !stop) begin
            if (abort_at >= 0 && pix_idx == abort_at) begin
                stop = 1'b1;
            end else begin
                vld = (mode == 2) ? bit'($urandom_range(0, 1)) : 1'b1;
                rdy = (mode == 1) ? (k % 3 == 0) : 1'b1;
                ldp = (mode == 3) && (k == 10 || state_dbg == 2'd2);
                cycle(vld, rdy, ldp);
                if (n_complete > 0) after++;
                k++;
            end
        end
        if (abort_at < 0) begin
            check("window_count", 128'(n_win), 128'((IMG_W-2)*(IMG_H-2)));
            check("queue_empty", 128'(exp_q.size()), 128'(0));
            check("complete_pulses", 128'(n_complete), 128'(1));
            if (tail > 1) check("state_idle", 128'(state_dbg), 128'(0));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  128'(in_ready),  128'(0));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_win"},       128'(win),       128'(0));
        check({tag, "_win_row"},   128'(win_row),   128'(0));
        check({tag, "_win_col"},   128'(win_col),   128'(0));
        check({tag, "_complete"},  128'(complete),  128'(0));
        check({tag, "_state"},     128'(state_dbg), 128'(0));
    endtask

    initial begin
        n_checks = 0; n_fail = 0; base = 0; pix_idx = 0;
        stalled_prev = 1'b0; held = '0;
        rst = 1'b0; ld = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;

        // Reset state
        #1;
        check_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_no_ready", 128'(in_ready), 128'(0));

        // Streaming frame
        run_frame(0, 0, -1, 4);
        // Output stalls
        run_frame(0, 1, -1, 4);
        // Random input gaps
        run_frame(0, 2, -1, 4);

        // Reset mid-frame after pixel 12 was accepted
        run_frame(0, 0, 13, 4);
        check("pre_reset_valid", 128'(out_valid), 128'(1));
        in_valid = 1'b0; ld = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame(0, 0, -1, 4);

        // ld pulsed during RUN and DONE
        run_frame(0, 3, -1, 4);

        // Back-to-back frames
        run_frame(0, 0, -1, 1);
        run_frame(100, 0, -1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
